branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Direct-mapped BTB with a 2-bit saturating counter per entry.
- IF side: combinational lookup on PCF produces PredictedF (registered downstream into PredictedD/PredictedE) and the next-fetch PC.
- EX side: consumes the resolved conditional branch together with PredictedE from the ID-EX segment register. It updates the table, flags a misprediction and supplies the redirect PC to the hazard/NPC logic.

Parameters:
- ENTRY_BITS, 6, log2 of entry count (64 entries); index = PC[ENTRY_BITS+1:2]
- TAG_BITS, 30-ENTRY_BITS, tag width; tag = PC[31:ENTRY_BITS+2]

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCF  in  32  fetch PC for lookup
- PredictedF  out  1  BTB predicts taken for PCF
- PredictedPCF  out  32  predicted next fetch PC
- PCE  in  32  PC of instruction in EX
- IsBranchE  in  1  EX holds a conditional branch (BranchTypeE != 0)
- BranchTakenE  in  1  resolved branch outcome
- BrTargetE  in  32  resolved branch target (BrNPC)
- PredictedE  in  1  prediction carried with the EX instruction
- UpdateEnE  in  1  EX stage advancing this cycle (stall = 0); table writes only when high
- MispredictE  out  1  prediction wrong; flush IF/ID and ID/EX
- RedirectPCE  out  32  correct next PC after a misprediction

Behaviour:
- Reset is async, active-low, and takes effect immediately, including mid-operation:
  - all valid bits, tags, targets and counters cleared to 0
  - therefore PredictedF = 0 and PredictedPCF = PCF+4 while reset is active and until the first allocation
- Entry fields: valid (1), tag (TAG_BITS), target (32), cnt (2).
- Lookup (combinational, zero latency):
  - hitF = valid[idxF] && tag[idxF]==tagF
  - PredictedF = hitF && cnt[idxF][1]
  - PredictedPCF = PredictedF ? target[idxF] : PCF+4
- Update: at posedge clk when UpdateEnE && IsBranchE.
  - On hit at the EX index:
    - taken: cnt = min(cnt+1, 3) and target <= BrTargetE
    - not taken: cnt = max(cnt-1, 0); target unchanged
  - On miss:
    - taken: allocate (overwrite) with valid=1, tag=tagE, target=BrTargetE, cnt=2'b10 (weakly taken)
    - not taken: no allocation, table unchanged
- No write when IsBranchE=0 or UpdateEnE=0. A stalled branch must update exactly once, on the cycle it advances.
- Counter saturation: 3 + taken stays 3; 0 + not-taken stays 0.
- Same-index lookup/update in one cycle: lookup returns pre-edge contents (no write bypass). The new state is visible from the next cycle.
- Aliasing: a tag mismatch is a miss. A taken miss evicts the resident entry.
- MispredictE (combinational, not gated by UpdateEnE) = IsBranchE && (PredictedE ^ BranchTakenE).
  - The target is always correct on a predicted-taken hit, because tag equality plus a fixed conditional-branch target guarantees it.
- RedirectPCE = BranchTakenE ? BrTargetE : PCE+4. Meaningful only when MispredictE=1.
- Arithmetic: all PC+4 is 32-bit modulo 2^32; 0xFFFFFFFC+4 = 0x00000000.
- JAL/JALR are not handled (IsBranchE=0 for them); the existing NPC path resolves those.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds two outputs:
  - BranchCount [31:0]: increments on every update event (UpdateEnE && IsBranchE).
  - MispredCount [31:0]: increments on update events where MispredictE=1.
  - Both reset to 0 asynchronously, both wrap modulo 2^32, and both increment on the same edge as the table update.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst_n=0 then 1, PCF=0x00000100 -> PredictedF=0, PredictedPCF=0x00000104. MispredictE=0 while IsBranchE=0.
- First taken branch:
  - PCE=0x00000100, IsBranchE=1, BranchTakenE=1, BrTargetE=0x00000080, PredictedE=0, UpdateEnE=1 -> MispredictE=1, RedirectPCE=0x00000080.
  - Next cycle, PCF=0x00000100 -> PredictedF=1, PredictedPCF=0x00000080.
- Counter hysteresis: after allocation (cnt=2), one not-taken update with PredictedE=1 -> MispredictE=1, RedirectPCE=0x00000104, cnt=1, PredictedF=0. Two taken updates -> cnt=3; a third taken update keeps cnt=3. One not-taken update -> cnt=2, still predicts taken.
- Aliasing: with entry for 0x00000100 resident (ENTRY_BITS=6), lookup PCF=0x00000200 (same index 0, different tag) -> PredictedF=0. A taken update at PCE=0x00000200 -> 0x00000100 now misses.
- Stall and same-cycle timing:
  - UpdateEnE=0 for 3 cycles with a taken branch held in EX -> table unchanged. UpdateEnE=1 on cycle 4 -> exactly one update.
  - Lookup of the same PC in the update cycle -> old value; the new value appears the next cycle.
- BP_STATS_EN: 5 branch updates with 2 mispredicts -> BranchCount=5, MispredCount=2. Asserting rst_n=0 mid-sequence clears both to 0 immediately.

Source files
------------

// File: rtl/branch_predict_unit_if.sv
// Fetch/execute signal bundle between the pipeline and branch_predict_unit.
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if;
  logic [31:0] PCF;
  logic        PredictedF;
  logic [31:0] PredictedPCF;
  logic [31:0] PCE;
  logic        IsBranchE;
  logic        BranchTakenE;
  logic [31:0] BrTargetE;
  logic        PredictedE;
  logic        UpdateEnE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;

  // Update qualifier: a resolved branch is consumed on a rising edge only when
  // IsBranchE and UpdateEnE are both high; UpdateEnE low holds it for a later cycle.
  modport master (
    output PCF, PCE, IsBranchE, BranchTakenE, BrTargetE, PredictedE, UpdateEnE,
    input  PredictedF, PredictedPCF, MispredictE, RedirectPCE
  );

  modport slave (
    input  PCF, PCE, IsBranchE, BranchTakenE, BrTargetE, PredictedE, UpdateEnE,
    output PredictedF, PredictedPCF, MispredictE, RedirectPCE
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit saturating counters; IF lookup, EX update/redirect.
// Optional BP_STATS_EN adds BranchCount/MispredCount statistics outputs.
module branch_predict_unit #(
  parameter int ENTRY_BITS = 6,
  parameter int TAG_BITS   = 30 - ENTRY_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_unit_if.slave  bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]           BranchCount,
  output logic [31:0]           MispredCount
`endif
);

  localparam int ENTRIES = 1 << ENTRY_BITS;

  logic                  valid_q  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [31:0]           target_q [ENTRIES];
  logic [1:0]            cnt_q    [ENTRIES];

  logic [ENTRY_BITS-1:0] idx_f, idx_e;
  logic [TAG_BITS-1:0]   tag_f, tag_e;
  logic                  hit_f, hit_e;
  logic                  update_en;

  assign idx_f = bp.PCF[ENTRY_BITS+1:2];
  assign tag_f = bp.PCF[31:ENTRY_BITS+2];
  assign idx_e = bp.PCE[ENTRY_BITS+1:2];
  assign tag_e = bp.PCE[31:ENTRY_BITS+2];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign bp.PredictedF   = hit_f && cnt_q[idx_f][1];
  assign bp.PredictedPCF = bp.PredictedF ? target_q[idx_f] : (bp.PCF + 32'd4);

  assign hit_e          = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign update_en      = bp.UpdateEnE && bp.IsBranchE;
  assign bp.MispredictE = bp.IsBranchE && (bp.PredictedE ^ bp.BranchTakenE);
  assign bp.RedirectPCE = bp.BranchTakenE ? bp.BrTargetE : (bp.PCE + 32'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'd0;
      end
    end else if (update_en) begin
      if (hit_e) begin
        if (bp.BranchTakenE) begin
          cnt_q[idx_e]    <= (cnt_q[idx_e] == 2'd3) ? 2'd3 : cnt_q[idx_e] + 2'd1;
          target_q[idx_e] <= bp.BrTargetE;
        end else begin
          cnt_q[idx_e]    <= (cnt_q[idx_e] == 2'd0) ? 2'd0 : cnt_q[idx_e] - 2'd1;
        end
      end else if (bp.BranchTakenE) begin
        // Taken miss evicts whatever alias occupies the slot, starting weakly taken.
        valid_q[idx_e]  <= 1'b1;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= bp.BrTargetE;
        cnt_q[idx_e]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount  <= 32'd0;
      MispredCount <= 32'd0;
    end else if (update_en) begin
      BranchCount <= BranchCount + 32'd1;
      if (bp.MispredictE) MispredCount <= MispredCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (stats checks when BP_STATS_EN).
module tb_branch_predict_unit;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [31:0] exp_q[$];

  branch_predict_unit_if bp();

`ifdef BP_STATS_EN
  logic [31:0] BranchCount, MispredCount;
  branch_predict_unit dut (.clk(clk), .rst_n(rst_n), .bp(bp),
                           .BranchCount(BranchCount), .MispredCount(MispredCount));
`else
  branch_predict_unit dut (.clk(clk), .rst_n(rst_n), .bp(bp));
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bp.PCF = 32'h0; bp.PCE = 32'h0; bp.IsBranchE = 1'b0; bp.BranchTakenE = 1'b0;
    bp.BrTargetE = 32'h0; bp.PredictedE = 1'b0; bp.UpdateEnE = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_branch(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt, input logic pred, input logic en);
    bp.PCE = pc; bp.IsBranchE = 1'b1; bp.BranchTakenE = taken;
    bp.BrTargetE = tgt; bp.PredictedE = pred; bp.UpdateEnE = en;
  endtask

  task automatic no_branch();
    bp.IsBranchE = 1'b0; bp.UpdateEnE = 1'b0; bp.BranchTakenE = 1'b0; bp.PredictedE = 1'b0;
  endtask

  // One committed update then idle, ending at a negedge.
  task automatic commit(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    drive_branch(pc, taken, tgt, 1'b0, 1'b1);
    step();
    no_branch();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    bp.PCF = 32'h100;
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h104) begin
      tests_failed++;
      $display("FAIL reset_in: pred=%b ppc=%h want 0/00000104", bp.PredictedF, bp.PredictedPCF);
    end
    step();
    rst_n = 1'b1;
    step();
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h104 || bp.MispredictE !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: pred=%b ppc=%h mis=%b want 0/00000104/0",
               bp.PredictedF, bp.PredictedPCF, bp.MispredictE);
    end
  endtask

  task automatic test_first_taken();
    apply_reset();
    bp.PCF = 32'h100;
    drive_branch(32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
    #1;
    tests_run++;
    if (bp.MispredictE !== 1'b1 || bp.RedirectPCE !== 32'h80) begin
      tests_failed++;
      $display("FAIL first_taken_ex: mis=%b redir=%h want 1/00000080", bp.MispredictE, bp.RedirectPCE);
    end
    step();
    no_branch();
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b1 || bp.PredictedPCF !== 32'h80) begin
      tests_failed++;
      $display("FAIL first_taken_if: pred=%b ppc=%h want 1/00000080", bp.PredictedF, bp.PredictedPCF);
    end
  endtask

  // Continues from test_first_taken: entry 0x100 at cnt=2.
  task automatic test_hysteresis();
    logic exp_pred [9];
    logic taken_seq [9];
    exp_pred  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    taken_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bp.PCF = 32'h100;
    drive_branch(32'h100, 1'b0, 32'h80, 1'b1, 1'b1);
    #1;
    tests_run++;
    if (bp.MispredictE !== 1'b1 || bp.RedirectPCE !== 32'h104) begin
      tests_failed++;
      $display("FAIL hyst_nt_ex: mis=%b redir=%h want 1/00000104", bp.MispredictE, bp.RedirectPCE);
    end
    step();
    no_branch();
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h104) begin
      tests_failed++;
      $display("FAIL hyst_cnt1: pred=%b ppc=%h want 0/00000104", bp.PredictedF, bp.PredictedPCF);
    end
    // cnt path from 1: T->2, T->3, T->3, NT->2, NT->1, NT->0, NT->0, T->1, T->2
    exp_pred = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      commit(32'h100, taken_seq[i], 32'h80);
      tests_run++;
      if (bp.PredictedF !== exp_pred[i]) begin
        tests_failed++;
        $display("FAIL hyst_step%0d: pred=%b want %b", i, bp.PredictedF, exp_pred[i]);
      end
    end
  endtask

  task automatic test_aliasing();
    apply_reset();
    commit(32'h100, 1'b1, 32'h80);
    bp.PCF = 32'h200;
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h204) begin
      tests_failed++;
      $display("FAIL alias_lookup: pred=%b ppc=%h want 0/00000204", bp.PredictedF, bp.PredictedPCF);
    end
    commit(32'h200, 1'b1, 32'h300);
    bp.PCF = 32'h100;
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h104) begin
      tests_failed++;
      $display("FAIL alias_evicted: pred=%b ppc=%h want 0/00000104", bp.PredictedF, bp.PredictedPCF);
    end
    commit(32'h400, 1'b0, 32'h999);
    bp.PCF = 32'h200;
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b1 || bp.PredictedPCF !== 32'h300) begin
      tests_failed++;
      $display("FAIL alias_nt_miss_keep: pred=%b ppc=%h want 1/00000300", bp.PredictedF, bp.PredictedPCF);
    end
    bp.PCF = 32'h400;
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h404) begin
      tests_failed++;
      $display("FAIL alias_nt_no_alloc: pred=%b ppc=%h want 0/00000404", bp.PredictedF, bp.PredictedPCF);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    bp.PCF = 32'h140;
    drive_branch(32'h140, 1'b1, 32'h40, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      tests_run++;
      if (bp.PredictedF !== 1'b0 || bp.MispredictE !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_cyc%0d: pred=%b mis=%b want 0/1", c, bp.PredictedF, bp.MispredictE);
      end
    end
    bp.UpdateEnE = 1'b1;
    step();
    no_branch();
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b1 || bp.PredictedPCF !== 32'h40) begin
      tests_failed++;
      $display("FAIL stall_release: pred=%b ppc=%h want 1/00000040", bp.PredictedF, bp.PredictedPCF);
    end
    // A single allocation leaves cnt=2, so one not-taken drops prediction.
    commit(32'h140, 1'b0, 32'h40);
    tests_run++;
    if (bp.PredictedF !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_once: pred=%b want 0", bp.PredictedF);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] got;
    apply_reset();
    bp.PCF = 32'h180;
    drive_branch(32'h180, 1'b1, 32'h20, 1'b0, 1'b1);
    exp_q.push_back(32'h184);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h20);
    #1;
    got = exp_q.pop_front();
    tests_run++;
    if (bp.PredictedPCF !== got) begin
      tests_failed++;
      $display("FAIL same_cycle_old: ppc=%h want %h", bp.PredictedPCF, got);
    end
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    tests_run++;
    if (bp.PredictedPCF !== got) begin
      tests_failed++;
      $display("FAIL same_cycle_new: ppc=%h want %h", bp.PredictedPCF, got);
    end
    bp.UpdateEnE = 1'b0;
    @(negedge clk);
    no_branch();
    #1;
    got = exp_q.pop_front();
    tests_run++;
    if (bp.PredictedPCF !== got) begin
      tests_failed++;
      $display("FAIL same_cycle_hold: ppc=%h want %h", bp.PredictedPCF, got);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    bp.PCF = 32'hFFFF_FFFC;
    drive_branch(32'hFFFF_FFFC, 1'b0, 32'h1000, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (bp.PredictedPCF !== 32'h0 || bp.RedirectPCE !== 32'h0 || bp.MispredictE !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap: ppc=%h redir=%h mis=%b want 0/0/1",
               bp.PredictedPCF, bp.RedirectPCE, bp.MispredictE);
    end
    bp.BranchTakenE = 1'b1;
    #1;
    tests_run++;
    if (bp.MispredictE !== 1'b0) begin
      tests_failed++;
      $display("FAIL mis_correct: mis=%b want 0", bp.MispredictE);
    end
    bp.IsBranchE = 1'b0; bp.BranchTakenE = 1'b0;
    #1;
    tests_run++;
    if (bp.MispredictE !== 1'b0) begin
      tests_failed++;
      $display("FAIL mis_nobranch: mis=%b want 0", bp.MispredictE);
    end
    commit(32'hFFFF_FFFC, 1'b1, 32'h1000);
    tests_run++;
    if (bp.PredictedF !== 1'b1 || bp.PredictedPCF !== 32'h1000) begin
      tests_failed++;
      $display("FAIL top_index: pred=%b ppc=%h want 1/00001000", bp.PredictedF, bp.PredictedPCF);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    commit(32'h100, 1'b1, 32'h80);
    bp.PCF = 32'h100;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bp.PredictedF !== 1'b0 || bp.PredictedPCF !== 32'h104) begin
      tests_failed++;
      $display("FAIL async_reset: pred=%b ppc=%h want 0/00000104", bp.PredictedF, bp.PredictedPCF);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    logic tk [5];
    logic pr [5];
    apply_reset();
    tk = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    pr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_branch(32'h500, tk[i], 32'h60, pr[i], 1'b1);
      step();
      drive_branch(32'h500, 1'b1, 32'h60, 1'b0, 1'b0);
      step();
    end
    no_branch();
    #1;
    tests_run++;
    if (BranchCount !== 32'd5 || MispredCount !== 32'd2) begin
      tests_failed++;
      $display("FAIL stats_count: br=%0d mis=%0d want 5/2", BranchCount, MispredCount);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (BranchCount !== 32'd0 || MispredCount !== 32'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: br=%0d mis=%0d want 0/0", BranchCount, MispredCount);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    idle_inputs();
    test_reset();
    test_first_taken();
    test_hysteresis();
    test_aliasing();
    test_stall();
    test_same_cycle();
    test_wrap();
    test_async_reset();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
